store_buffer: RTL

//   Memory-stage store buffer between the pipelined core's M-stage data port and data memory.
//   - Stores (MemWriteM) are queued in a small FIFO and drained to memory through a valid/ready write port.
//   - Loads see the youngest pending store to the same word, or memory read data.
//   - When the buffer cannot accept a store, it raises a stall to the hazard unit.

---
 rtl/store_buffer_if.sv | 27 ++
 rtl/store_buffer.sv | 97 +++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// Core-side and memory-side signals of the store buffer.
// The slave modport is the buffer itself; the master modport drives it (core plus memory model).
interface store_buffer_if;
    logic        MemWriteM;
    logic        MemtoRegM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallSB;
    logic        SBEmpty;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_wvalid;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wready;

    modport slave (
        input  MemWriteM, MemtoRegM, ALUOutM, WriteDataM, mem_rdata, mem_wready,
        output ReadDataM, StallSB, SBEmpty, mem_raddr, mem_wvalid, mem_waddr, mem_wdata
    );

    modport master (
        output MemWriteM, MemtoRegM, ALUOutM, WriteDataM, mem_rdata, mem_wready,
        input  ReadDataM, StallSB, SBEmpty, mem_raddr, mem_wvalid, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/store_buffer.sv
// M-stage store buffer: in-order FIFO of word stores drained over a valid/ready write port.
// Define STORE_FWD_EN to forward the youngest matching store to loads; otherwise matching loads stall.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  sb
);
    localparam int             PW       = $clog2(DEPTH);
    localparam logic [PW:0]    FULL_CNT = (PW+1)'(DEPTH);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic [29:0]   r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];

    logic             w_full;
    logic             w_empty;
    logic             w_enq;
    logic             w_pop;
    logic             w_stall;
    logic [DEPTH-1:0] w_match;   // bit k: entry k places back from the newest matches the load address

`ifdef STORE_FWD_EN
    logic [31:0] w_age_data [DEPTH];
    logic        w_fwd_hit;
    logic [31:0] w_fwd_data;
`endif

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        logic [PW-1:0] w_idx;
        assign w_idx       = r_wr_ptr - PW'(gi + 1);
        assign w_match[gi] = ((PW+1)'(gi) < r_count) && (r_addr[w_idx] == sb.ALUOutM[31:2]);
`ifdef STORE_FWD_EN
        assign w_age_data[gi] = r_data[w_idx];
`endif
    end

`ifdef STORE_FWD_EN
    // Scan oldest to youngest so the youngest match is the one that sticks.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = w_age_data[k];
            end
        end
    end

    assign w_stall      = sb.MemWriteM && w_full;
    assign sb.ReadDataM = (sb.MemtoRegM && w_fwd_hit) ? w_fwd_data : sb.mem_rdata;
`else
    assign w_stall      = (sb.MemWriteM && w_full) || (sb.MemtoRegM && (|w_match));
    assign sb.ReadDataM = sb.mem_rdata;
`endif

    // A pop in the same cycle does not free a slot for a stalled store.
    assign w_enq = sb.MemWriteM && !w_stall;
    assign w_pop = !w_empty && sb.mem_wready;

    assign sb.StallSB    = w_stall;
    assign sb.SBEmpty    = w_empty;
    assign sb.mem_raddr  = sb.ALUOutM;
    assign sb.mem_wvalid = !w_empty;
    assign sb.mem_waddr  = {r_addr[r_rd_ptr], 2'b00};
    assign sb.mem_wdata  = r_data[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_wr_ptr] <= sb.ALUOutM[31:2];
            r_data[r_wr_ptr] <= sb.WriteDataM;
        end
    end
endmodule
